spi_accel_master: RTL

- SPI mode-0 master that runs one accelerometer register-read burst per `start` pulse.
- Each burst sends the read command 0x0B and a register address, then clocks in two data bytes.
- It delivers the pair as one 16-bit word with a single-cycle write pulse into the receive FIFO.
- Sits between the accelerometer pins and the FIFO write side (write pulse + 16-bit data in).

---
 rtl/spi_accel_master_if.sv | 25 ++
 rtl/spi_accel_master.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/spi_accel_master_if.sv
// Signal bundle between the accelerometer SPI master, the sensor pins and the
// receive-FIFO write side.
interface spi_accel_master_if;
  logic        start;
  logic [7:0]  reg_addr;
  logic        fifo_full;
  logic        miso;
  logic        sclk;
  logic        mosi;
  logic        cs_n;
  logic        busy;
  logic        word_valid;
  logic [15:0] data_out;
  logic        overflow;

  modport master (
    input  start, reg_addr, fifo_full, miso,
    output sclk, mosi, cs_n, busy, word_valid, data_out, overflow
  );

  modport slave (
    output start, reg_addr, fifo_full, miso,
    input  sclk, mosi, cs_n, busy, word_valid, data_out, overflow
  );
endinterface

// File: rtl/spi_accel_master.sv
// SPI mode-0 master: one read burst (command, address, two data bytes) per start,
// delivered as a single 16-bit word with a one-cycle write pulse.
module spi_accel_master #(
  parameter int unsigned CLK_DIV = 50,
  parameter logic [7:0]  RD_CMD  = 8'h0B
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_accel_master_if.master spi_io
);

  localparam int unsigned     DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [5:0]      NumBits = 6'd32;

  typedef enum logic [2:0] {StIdle, StCsSetup, StShift, StCsHold, StGap} state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [5:0]      bit_q, bit_d;
  logic [31:0]     tx_q, tx_d;
  logic [15:0]     rx_q, rx_d;
  logic            sclk_q, sclk_d;
  logic            cs_n_q, cs_n_d;
  logic            busy_q, busy_d;
  logic            wv_q, wv_d;
  logic [15:0]     data_q, data_d;
  logic            ovf_q, ovf_d;
  logic            div_done;

  assign div_done = (div_q == DivLast);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    busy_d  = busy_q;
    wv_d    = 1'b0;
    data_d  = data_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (spi_io.start && !spi_io.fifo_full) begin
          tx_d    = {RD_CMD, spi_io.reg_addr, 16'h0000};
          bit_d   = 6'd0;
          div_d   = '0;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = StCsSetup;
        end
      end
      StCsSetup: begin
        if (div_done) begin
          div_d   = '0;
          state_d = StShift;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StShift: begin
        if (div_done) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            // Only the last 16 bits survive in rx; command/address-phase MISO falls out.
            rx_d  = {rx_q[14:0], spi_io.miso};
            bit_d = bit_q + 6'd1;
          end else begin
            tx_d = {tx_q[30:0], 1'b0};
            if (bit_q == NumBits) begin
              state_d = StCsHold;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StCsHold: begin
        if (div_done) begin
          div_d   = '0;
          cs_n_d  = 1'b1;
          // First data byte received becomes the low byte.
          data_d  = {rx_q[7:0], rx_q[15:8]};
          wv_d    = 1'b1;
          ovf_d   = ovf_q | spi_io.fifo_full;
          state_d = StGap;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StGap: begin
        if (div_done) begin
          div_d   = '0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      wv_q    <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      wv_q    <= wv_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  // tx is all zeros outside a burst, so mosi idles low without extra gating.
  assign spi_io.sclk       = sclk_q;
  assign spi_io.mosi       = tx_q[31];
  assign spi_io.cs_n       = cs_n_q;
  assign spi_io.busy       = busy_q;
  assign spi_io.word_valid = wv_q;
  assign spi_io.data_out   = data_q;
  assign spi_io.overflow   = ovf_q;

endmodule
